// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - carry-pipelined adder, SEG bits per stage; PIPE_ADDER_SUB_EN adds a sub port
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = WIDTH / SEG;

  // The whole pipe moves as one: it only holds when the output slot is full and unread.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is folded into the operands up front: x + ~y + 1.
  logic [WIDTH-1:0] y_eff;
  logic             cin_eff;
`ifdef PIPE_ADDER_SUB_EN
  assign y_eff   = sub ? ~y : y;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign y_eff   = y;
  assign cin_eff = cin;
`endif

  // Stage k consumes the low SEG bits of its operand slice and forwards the rest,
  // so operand registers shrink and result registers grow down the pipe.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int REM = WIDTH - k * SEG;

    logic [REM-1:0]       a_in;
    logic [REM-1:0]       b_in;
    logic                 c_in;
    logic                 v_in;
    logic [SEG:0]         seg_sum;
    logic [(k+1)*SEG-1:0] s_d;
    logic                 v_q;
    logic                 c_q;
    logic [(k+1)*SEG-1:0] s_q;

    if (k == 0) begin : g_head
      assign a_in = x;
      assign b_in = y_eff;
      assign c_in = cin_eff;
      assign v_in = in_valid;
      assign s_d  = seg_sum[SEG-1:0];
    end else begin : g_body
      assign a_in = g_st[k-1].g_fwd.a_q;
      assign b_in = g_st[k-1].g_fwd.b_q;
      assign c_in = g_st[k-1].c_q;
      assign v_in = g_st[k-1].v_q;
      assign s_d  = {seg_sum[SEG-1:0], g_st[k-1].s_q};
    end

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

    // Slot valid, segment carry and accumulated low result bits.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= seg_sum[SEG];
        s_q <= s_d;
      end
    end

    if (REM > SEG) begin : g_fwd
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      // Operand bits not yet added travel alongside their own carry.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[REM-1:SEG];
          b_q <= b_in[REM-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is recovered as s ^ a ^ b at the MSB position.
      assign ovf_d = seg_sum[SEG] ^ seg_sum[SEG-1] ^ a_in[SEG-1] ^ b_in[SEG-1];

      // Signed overflow is registered with the final segment.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign sum       = g_st[STAGES-1].s_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign out_valid = g_st[STAGES-1].v_q;
  assign ovf       = g_st[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboarded vector bench for pipe_adder
module tb_pipe_adder;
  localparam int WIDTH  = 16;
  localparam int SEG    = 4;
  localparam int STAGES = WIDTH / SEG;
`ifdef PIPE_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] x_r;
  logic [15:0] y_r;
  logic        cin_r;
`ifdef PIPE_ADDER_SUB_EN
  logic        sub_r;
`endif
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  exp_t cur_exp;
  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  bit   rand_ready = 1'b0;

  pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x_r),
    .y         (y_r),
    .cin       (cin_r),
`ifdef PIPE_ADDER_SUB_EN
    .sub       (sub_r),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
    logic [15:0] bb;
    logic        cc;
    logic [16:0] t;
    exp_t        r;
    bb  = s ? ~b : b;
    cc  = s ? 1'b1 : c;
    t   = {1'b0, a} + {1'b0, bb} + {16'b0, cc};
    r.s = t[15:0];
    r.c = t[16];
    r.o = (a[15] == bb[15]) && (t[15] != a[15]);
    return r;
  endfunction

  // Scoreboard: pop/compare on each consumed result, push on each accepted operand set.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        exp_t e;
        if (sb.size() == 0) begin
          check("unexpected_output", {47'b0, out_valid, sum}, 64'h0);
        end else begin
          e = sb.pop_front();
          check($sformatf("sum[%0d]", n_out), sum, e.s);
          check($sformatf("cout[%0d]", n_out), cout, e.c);
          check($sformatf("ovf[%0d]", n_out), ovf, e.o);
        end
        n_out++;
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic drive(input vec_t v);
    x_r       = v.a;
    y_r       = v.b;
    cin_r     = v.ci;
`ifdef PIPE_ADDER_SUB_EN
    sub_r     = v.sb;
`endif
    cur_exp.s = v.es;
    cur_exp.c = v.ec;
    cur_exp.o = v.eo;
    in_valid  = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int t;
    @(negedge clk);
    drive(v);
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    t = 0;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      t++;
    end
    check("accept_in_time", in_ready, 1);
    @(posedge clk);
  endtask

  task automatic drain();
    int i;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    i = 0;
    #2;
    while ((sb.size() != 0 || out_valid) && i < 100) begin
      @(negedge clk);
      #2;
      i++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Called at a negedge with an empty pipe; counts edges from acceptance to out_valid.
  task automatic latency_op(input vec_t v, input string name);
    int n;
    out_ready = 1'b1;
    drive(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, STAGES);
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic c,
                              input logic s, input logic [15:0] es, input logic ec,
                              input logic eo);
    vec_t v;
    v.a = a; v.b = b; v.ci = c; v.sb = s; v.es = es; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;

    tbl.push_back(mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0));
    tbl.push_back(mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
    tbl.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
    tbl.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
    tbl.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0));
    tbl.push_back(mk(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0));
    tbl.push_back(mk(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
`ifdef PIPE_ADDER_SUB_EN
    tbl.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
    tbl.push_back(mk(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1));
    tbl.push_back(mk(16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_r       = '0;
    y_r       = '0;
    cin_r     = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
    sub_r     = 1'b0;
`endif
    cur_exp   = '{s: 16'h0, c: 1'b0, o: 1'b0};

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);

    // First edge after reset release accepts; carry must ripple through all stages.
    @(negedge clk);
    rst = 1'b0;
    latency_op(tbl[0], "latency_carry_chain");
    drain();

    // Table vectors streamed back to back.
    foreach (tbl[i]) send(tbl[i]);
    drain();

    // Back-to-back 1+1..4+4 with a 3-cycle stall after the first result.
    for (int i = 1; i <= 4; i++) begin
      v = mk(16'(i), 16'(i), 1'b0, 1'b0, 16'(2 * i), 1'b0, 1'b0);
      @(negedge clk);
      drive(v);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_sum_held", sum, 16'd4);
      check("stall_out_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain();
    check("stall_results_seen", n_out, tbl.size() + 5);

    // Three operations in flight, then a one-cycle reset.
    for (int i = 0; i < 3; i++) begin
      v = mk(16'h0100 + 16'(i), 16'h0001, 1'b0, 1'b0, 16'h0101 + 16'(i), 1'b0, 1'b0);
      @(negedge clk);
      drive(v);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_idle", out_valid, 0);
      @(negedge clk);
    end
    latency_op(tbl[2], "latency_after_reset");
    drain();

    // Random operands with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      v.a  = 16'($urandom);
      v.b  = 16'($urandom);
      v.ci = 1'($urandom_range(0, 1));
      v.sb = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
      e    = model(v.a, v.b, v.ci, v.sb);
      v.es = e.s;
      v.ec = e.c;
      v.eo = e.o;
      send(v);
    end
    rand_ready = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
